// File: rtl/prbs31_burst_ctrl.sv
// Burst/continuous sequencer for the 32-bit parallel PRBS31 step (x^31 + x^28 + 1).
// Optional error injection on the byte stream is built in when PRBS31_ERRINJ_EN is defined.
module prbs31_burst_ctrl #(
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         cfg_byte,
  input  logic               cfg_we,
  input  logic               start,
  input  logic               abort,
  input  logic [BURST_W-1:0] burst_len,
`ifdef PRBS31_ERRINJ_EN
  input  logic               err_inject,
`endif
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] words_sent,
  output logic               seed_fixed
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Word bit i is sequence bit 32t+31-i (MSB oldest); each new bit is z[n-28] ^ z[n-31].
  function automatic logic [31:0] prbs31(input logic [31:0] w);
    logic [63:0] z;
    logic [31:0] r;
    z = '0;
    for (int k = 0; k < 32; k++) z[k] = w[31-k];
    for (int n = 32; n < 64; n++) z[n] = z[n-28] ^ z[n-31];
    for (int i = 0; i < 32; i++) r[i] = z[63-i];
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        seed_q, seed_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         idx_q, idx_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] words_sent_q, words_sent_d;
  logic               done_q, done_d;
  logic               seed_fixed_q, seed_fixed_d;
  logic [31:0]        seed_eff;
  logic [BURST_W-1:0] words_inc;
  logic [7:0]         byte_sel;
  logic               handshake;
`ifdef PRBS31_ERRINJ_EN
  logic               err_pend_q, err_pend_d;
`endif

  assign handshake = (state_q == S_RUN) && out_ready;
  assign seed_eff  = (seed_q == 32'd0) ? 32'h0000_0001 : seed_q;
  assign words_inc = words_sent_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    word_d       = word_q;
    idx_d        = idx_q;
    len_d        = len_q;
    words_sent_d = words_sent_q;
    done_d       = 1'b0;
    seed_fixed_d = seed_fixed_q;
`ifdef PRBS31_ERRINJ_EN
    err_pend_d   = err_pend_q;
`endif

    // Seed writes only land while idle; a start in the same cycle still sees the old seed.
    if (state_q == S_IDLE && cfg_we) seed_d = {seed_q[23:0], cfg_byte};

    if (abort) begin
      state_d = S_IDLE;
`ifdef PRBS31_ERRINJ_EN
      err_pend_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            seed_fixed_d = (seed_q == 32'd0);
            len_d        = burst_len;
            word_d       = prbs31(seed_eff);
            idx_d        = 2'd3;
            words_sent_d = '0;
            state_d      = S_RUN;
          end
        end
        S_RUN: begin
`ifdef PRBS31_ERRINJ_EN
          if (handshake) err_pend_d = 1'b0;
          if (err_inject) err_pend_d = 1'b1;
`endif
          if (handshake) begin
            if (idx_q == 2'd0) begin
              word_d       = prbs31(word_q);
              idx_d        = 2'd3;
              words_sent_d = words_inc;
              if (len_q != '0 && words_inc == len_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d = idx_q - 2'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      seed_q       <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      words_sent_q <= '0;
      done_q       <= 1'b0;
      seed_fixed_q <= 1'b0;
`ifdef PRBS31_ERRINJ_EN
      err_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      words_sent_q <= words_sent_d;
      done_q       <= done_d;
      seed_fixed_q <= seed_fixed_d;
`ifdef PRBS31_ERRINJ_EN
      err_pend_q   <= err_pend_d;
`endif
    end
  end

  always_comb begin
    case (idx_q)
      2'd3:    byte_sel = word_q[31:24];
      2'd2:    byte_sel = word_q[23:16];
      2'd1:    byte_sel = word_q[15:8];
      default: byte_sel = word_q[7:0];
    endcase
  end

`ifdef PRBS31_ERRINJ_EN
  assign out_data = byte_sel ^ {7'd0, err_pend_q};
`else
  assign out_data = byte_sel;
`endif
  assign out_valid  = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign words_sent = words_sent_q;
  assign seed_fixed = seed_fixed_q;

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// Scoreboard bench for prbs31_burst_ctrl: stimulus pushes expected bytes, a monitor pops them on handshakes.
// Define PRBS31_ERRINJ_EN to include the error-injection scenario.
module tb_prbs31_burst_ctrl;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    cfg_byte = '0;
  logic          cfg_we = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [BW-1:0] words_sent;
  logic          seed_fixed;
`ifdef PRBS31_ERRINJ_EN
  logic          err_inject = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int hs_count = 0;
  int hs_at_done = -1;
  logic [7:0] exp_q[$];

  prbs31_burst_ctrl #(.BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_byte(cfg_byte), .cfg_we(cfg_we),
    .start(start), .abort(abort), .burst_len(burst_len),
`ifdef PRBS31_ERRINJ_EN
    .err_inject(err_inject),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .words_sent(words_sent), .seed_fixed(seed_fixed)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Bit-serial reference: shift one sequence bit at a time, 32 bits per word.
  function automatic logic [31:0] model_next(input logic [31:0] w);
    logic [31:0] sr;
    sr = w;
    for (int i = 0; i < 32; i++) sr = {sr[30:0], sr[27] ^ sr[30]};
    return sr;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_bytes(input logic [63:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[8*i +: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic write_seed(input logic [31:0] s);
    for (int i = 3; i >= 0; i--) begin
      cfg_we = 1'b1;
      cfg_byte = s[8*i +: 8];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [BW-1:0] len);
    burst_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns in the first cycle with busy low; done must be high in exactly that cycle.
  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        check_output({name, "_done_at_end"}, 32'(done), 32'd1);
        check_output({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s_timeout: busy still %0d after %0d cycles, required 0", name, busy, bound);
  endtask

  // Monitor: compares every transferred byte and checks stalled bytes against the queue head.
  always @(negedge clk) begin
    if (!rst_n && done) begin
      done_count++;
      hs_at_done = hs_count;
    end
    if (!rst_n && out_valid) begin
      if (out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %h, required none", out_data);
        end else begin
          check_output("stream_byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end else if (exp_q.size() != 0) begin
        check_output("stall_hold", 32'(out_data), 32'(exp_q[0]));
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [3:0] pat;
    pat = 4'b1001;

    do_reset();
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_words_sent", 32'(words_sent), 32'd0);
    check_output("rst_seed_fixed", 32'(seed_fixed), 32'd0);

    $display("[TB] basic burst, seed 1, len 2");
    write_seed(32'h0000_0001);
    out_ready = 1'b1;
    done_count = 0;
    push_bytes(64'h00000012_00000104);
    apply_stimulus(4'd2);
    check_output("t1_busy_after_start", 32'(busy), 32'd1);
    wait_idle("t1", 20);
    check_output("t1_words_sent", 32'(words_sent), 32'd2);
    check_output("t1_seed_fixed", 32'(seed_fixed), 32'd0);
    check_output("t1_out_valid_end", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_output("t1_done_count", 32'(done_count), 32'd1);

    $display("[TB] stalled burst, ready pattern 1,0,0,1");
    done_count = 0;
    hs_count = 0;
    push_bytes(64'h00000012_00000104);
    apply_stimulus(4'd2);
    for (int c = 0; c < 60 && busy; c++) begin
      out_ready = pat[3 - (c % 4)];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check_output("t2_idle", 32'(busy), 32'd0);
    check_output("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("t2_words_sent", 32'(words_sent), 32'd2);
    @(posedge clk); #1;
    check_output("t2_done_count", 32'(done_count), 32'd1);
    check_output("t2_hs_at_done", 32'(hs_at_done), 32'd8);

    $display("[TB] zero seed substitution");
    do_reset();
    done_count = 0;
    push_bytes(64'h00000000_00000012);
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    apply_stimulus(4'd1);
    check_output("t3_seed_fixed", 32'(seed_fixed), 32'd1);
    wait_idle("t3", 10);
    check_output("t3_words_sent", 32'(words_sent), 32'd1);

    $display("[TB] continuous mode with wrap and abort");
    do_reset();
    write_seed(32'h0000_0001);
    done_count = 0;
    w = 32'h0000_0001;
    for (int i = 0; i < 18; i++) begin
      w = model_next(w);
      if (i < 17) push_word(w);
      else begin
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
      end
    end
    apply_stimulus(4'd0);
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      if (i == 60) check_output("t4_words_15", 32'(words_sent), 32'd15);
      if (i == 64) begin
        check_output("t4_words_wrap", 32'(words_sent), 32'd0);
        check_output("t4_busy_after_wrap", 32'(busy), 32'd1);
      end
    end
    abort = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("t4_abort_valid", 32'(out_valid), 32'd0);
    check_output("t4_abort_busy", 32'(busy), 32'd0);
    check_output("t4_abort_words", 32'(words_sent), 32'd1);
    check_output("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check_output("t4_no_done", 32'(done_count), 32'd0);

    $display("[TB] ignored commands");
    out_ready = 1'b1;
    done_count = 0;
    push_bytes(64'h00000012_00000104);
    apply_stimulus(4'd2);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; cfg_we = 1'b1; cfg_byte = 8'hAB;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    wait_idle("t5", 20);
    check_output("t5_words_sent", 32'(words_sent), 32'd2);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_output("t5_start_abort_busy", 32'(busy), 32'd0);
    check_output("t5_start_abort_words", 32'(words_sent), 32'd2);
    push_bytes(64'h00000000_00000012);
    repeat (4) void'(exp_q.pop_front());
    apply_stimulus(4'd1);
    wait_idle("t5_rerun", 10);

    $display("[TB] seed write coinciding with start");
    push_bytes(64'h00000000_00000012);
    repeat (4) void'(exp_q.pop_front());
    cfg_we = 1'b1; cfg_byte = 8'h05;
    apply_stimulus(4'd1);
    cfg_we = 1'b0;
    wait_idle("t6_old_seed", 10);
    push_word(model_next(32'h0000_0105));
    apply_stimulus(4'd1);
    wait_idle("t6_new_seed", 10);
    check_output("t6_done_count", 32'(done_count), 32'd3);

`ifdef PRBS31_ERRINJ_EN
    $display("[TB] error injection on first byte");
    do_reset();
    write_seed(32'h0000_0001);
    out_ready = 1'b0;
    push_bytes(64'h01000012_00000104);
    apply_stimulus(4'd2);
    err_inject = 1'b1;
    @(posedge clk); #1;
    err_inject = 1'b0;
    out_ready = 1'b1;
    wait_idle("t7", 20);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
